// File: rtl/hex_display_ctrl_if.sv
// Load/status/segment bundle between a display source and hex_display_ctrl.
// The source holds the master side; the controller holds the slave side.
interface hex_display_ctrl_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_DIGITS = 6
);
  logic                    Load;
  logic [WIDTH-1:0]        Value;
  logic                    Mode;
  logic                    Blank_zeros;
  logic                    Busy;
  logic                    Done;
  logic [8*NUM_DIGITS-1:0] HEX_out;

  modport master (
    output Load, Value, Mode, Blank_zeros,
    input  Busy, Done, HEX_out
  );

  modport slave (
    input  Load, Value, Mode, Blank_zeros,
    output Busy, Done, HEX_out
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment controller: hex or signed-decimal (sequential double-dabble) rendering
// with leading-zero blanking, minus sign and overflow indication. Active-low segments.
module hex_display_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_DIGITS = 6
) (
  input logic               Clk,
  input logic               Reset_h,
  hex_display_ctrl_if.slave bus_io
);
  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        val_q, val_d;
  logic                    mode_q, mode_d;
  logic                    blank_q, blank_d;
  logic                    neg_q, neg_d;
  logic [BcdW-1:0]         bcd_q, bcd_d;
  logic                    sticky_q, sticky_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    done_q, done_d;

  logic [BcdW-1:0]         bcd_adj;
  logic [BcdW-1:0]         hex_nib;
  logic [3:0]              digs [NUM_DIGITS];
  int                      top_idx;
  logic                    ovf;
  logic [8*NUM_DIGITS-1:0] image;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  // Hex nibbles above WIDTH read as zero.
  for (genvar b = 0; b < BcdW; b++) begin : g_nib
    if (b < WIDTH) begin : g_val
      assign hex_nib[b] = val_q[b];
    end else begin : g_zero
      assign hex_nib[b] = 1'b0;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    top_idx = 0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digs[i] = mode_q ? bcd_q[4*i +: 4] : hex_nib[4*i +: 4];
      if (digs[i] != 4'd0) top_idx = i;
    end
    ovf   = mode_q && (sticky_q || (bcd_q[BcdW-1 -: 4] != 4'd0));
    image = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      image[8*i +: 8] = (blank_q && (i > top_idx)) ? 8'hFF : seg7(digs[i]);
    end
    // Top digit doubles as the sign position in decimal mode.
    if (mode_q) begin
      image[8*(NUM_DIGITS-1) +: 8] = neg_q ? 8'hBF : (blank_q ? 8'hFF : 8'hC0);
    end
    if (ovf) image = {NUM_DIGITS{8'hBF}};
  end

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    mode_d   = mode_q;
    blank_d  = blank_q;
    neg_d    = neg_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.Load) begin
          mode_d   = bus_io.Mode;
          blank_d  = bus_io.Blank_zeros;
          neg_d    = bus_io.Mode & bus_io.Value[WIDTH-1];
          val_d    = (bus_io.Mode && bus_io.Value[WIDTH-1]) ? -bus_io.Value : bus_io.Value;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = bus_io.Mode ? StConv : StUpdate;
        end
      end
      StConv: begin
        bcd_d    = {bcd_adj[BcdW-2:0], val_q[WIDTH-1]};
        val_d    = {val_q[WIDTH-2:0], 1'b0};
        sticky_d = sticky_q | bcd_adj[BcdW-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StUpdate;
      end
      StUpdate: begin
        hex_d   = image;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q  <= StIdle;
      val_q    <= '0;
      mode_q   <= 1'b0;
      blank_q  <= 1'b0;
      neg_q    <= 1'b0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      hex_q    <= {NUM_DIGITS{8'hFF}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      mode_q   <= mode_d;
      blank_q  <= blank_d;
      neg_q    <= neg_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.Busy    = (state_q != StIdle);
  assign bus_io.Done    = done_q;
  assign bus_io.HEX_out = hex_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: a 6-digit and a 4-digit instance, WIDTH=16,
// checking latency, Busy/Done timing, segment images, dropped loads and reset abort.
module tb_hex_display_ctrl;
  logic Clk;
  logic Reset_h;
  int   n_cmp;
  int   n_err;
  logic [47:0] disp6;

  hex_display_ctrl_if #(.WIDTH(16), .NUM_DIGITS(6)) a6 ();
  hex_display_ctrl_if #(.WIDTH(16), .NUM_DIGITS(4)) a4 ();

  hex_display_ctrl #(.WIDTH(16), .NUM_DIGITS(6)) u_dut6 (
    .Clk    (Clk),
    .Reset_h(Reset_h),
    .bus_io (a6)
  );

  hex_display_ctrl #(.WIDTH(16), .NUM_DIGITS(4)) u_dut4 (
    .Clk    (Clk),
    .Reset_h(Reset_h),
    .bus_io (a4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load one value into the 6-digit unit; optional extra Load pulse at sample intr_k.
  task automatic run6(input string tag, input logic [15:0] v, input logic m, input logic bz,
                      input int lat, input logic [47:0] exp_img, input int intr_k);
    int   busy_cnt;
    int   done_cnt;
    int   done_at;
    logic early;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    early    = 1'b0;
    @(negedge Clk);
    a6.Load = 1'b1; a6.Value = v; a6.Mode = m; a6.Blank_zeros = bz;
    @(negedge Clk);
    a6.Load = 1'b0; a6.Value = 16'h1234; a6.Mode = ~m; a6.Blank_zeros = ~bz;
    for (int k = 0; k < 24; k++) begin
      if (a6.Busy) busy_cnt++;
      if (a6.Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done_cnt == 0 && a6.HEX_out !== disp6) early = 1'b1;
      if (k == intr_k) begin
        a6.Load = 1'b1; a6.Value = 16'hFFFF; a6.Mode = 1'b1;
      end else begin
        a6.Load = 1'b0;
      end
      @(negedge Clk);
    end
    check({tag, "_done_at"}, 64'(done_at), 64'(lat));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(lat));
    check({tag, "_early_update"}, 64'(early), 64'd0);
    check({tag, "_image"}, 64'(a6.HEX_out), 64'(exp_img));
    disp6 = exp_img;
  endtask

  task automatic run4(input string tag, input logic [15:0] v, input logic bz,
                      input logic [31:0] exp_img);
    int done_at;
    done_at = -1;
    @(negedge Clk);
    a4.Load = 1'b1; a4.Value = v; a4.Mode = 1'b1; a4.Blank_zeros = bz;
    @(negedge Clk);
    a4.Load = 1'b0; a4.Value = 16'h0000; a4.Mode = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (a4.Done && done_at < 0) done_at = k;
      @(negedge Clk);
    end
    check({tag, "_done_at"}, 64'(done_at), 64'd17);
    check({tag, "_image"}, 64'(a4.HEX_out), 64'(exp_img));
  endtask

  initial begin
    int done_cnt;
    n_cmp   = 0;
    n_err   = 0;
    Reset_h = 1'b1;
    a6.Load = 1'b0; a6.Value = '0; a6.Mode = 1'b0; a6.Blank_zeros = 1'b0;
    a4.Load = 1'b0; a4.Value = '0; a4.Mode = 1'b0; a4.Blank_zeros = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_hex6", 64'(a6.HEX_out), 64'h0000_FFFF_FFFF_FFFF);
    check("rst_busy6", 64'(a6.Busy), 64'd0);
    check("rst_done6", 64'(a6.Done), 64'd0);
    check("rst_hex4", 64'(a4.HEX_out), 64'h0000_0000_FFFF_FFFF);
    Reset_h = 1'b0;
    disp6   = 48'hFFFF_FFFF_FFFF;

    run6("dec_m123", 16'hFF85, 1'b1, 1'b1, 17, 48'hBF_FF_FF_F9_A4_B0, -1);
    run6("hex_beef_nb", 16'hBEEF, 1'b0, 1'b0, 1, 48'hC0_C0_83_86_86_8E, -1);
    run6("hex_beef_bl", 16'hBEEF, 1'b0, 1'b1, 1, 48'hFF_FF_83_86_86_8E, -1);
    run6("hex_5_bl", 16'h0005, 1'b0, 1'b1, 1, 48'hFF_FF_FF_FF_FF_92, -1);
    run6("hex_0_nb", 16'h0000, 1'b0, 1'b0, 1, 48'hC0_C0_C0_C0_C0_C0, -1);
    run6("dec_min", 16'h8000, 1'b1, 1'b0, 17, 48'hBF_B0_A4_F8_82_80, -1);
    run6("dec_max", 16'h7FFF, 1'b1, 1'b0, 17, 48'hC0_B0_A4_F8_82_F8, -1);
    run6("dec_zero_bl", 16'h0000, 1'b1, 1'b1, 17, 48'hFF_FF_FF_FF_FF_C0, -1);
    run6("dec_42_drop", 16'd42, 1'b1, 1'b1, 17, 48'hFF_FF_FF_FF_99_A4, 4);

    run4("d4_12345", 16'd12345, 1'b1, 32'hBF_BF_BF_BF);
    run4("d4_999_bl", 16'd999, 1'b1, 32'hFF_90_90_90);
    run4("d4_999_nb", 16'd999, 1'b0, 32'hC0_90_90_90);
    run4("d4_9999", 16'd9999, 1'b1, 32'hBF_BF_BF_BF);
    run4("d4_m5_bl", 16'hFFFB, 1'b1, 32'hBF_FF_FF_92);

    // Reset part-way through a conversion.
    @(negedge Clk);
    a6.Load = 1'b1; a6.Value = 16'd500; a6.Mode = 1'b1; a6.Blank_zeros = 1'b0;
    @(negedge Clk);
    a6.Load = 1'b0;
    repeat (7) @(negedge Clk);
    Reset_h = 1'b1;
    @(negedge Clk);
    check("abort_busy", 64'(a6.Busy), 64'd0);
    check("abort_done", 64'(a6.Done), 64'd0);
    check("abort_hex", 64'(a6.HEX_out), 64'h0000_FFFF_FFFF_FFFF);
    Reset_h  = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (a6.Done) done_cnt++;
      @(negedge Clk);
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_hex_hold", 64'(a6.HEX_out), 64'h0000_FFFF_FFFF_FFFF);
    disp6 = 48'hFFFF_FFFF_FFFF;
    run6("post_rst_7", 16'd7, 1'b1, 1'b0, 17, 48'hC0_C0_C0_C0_C0_F8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
